// File: rtl/apu_dmc_reader_if.sv
// CPU register bus and DMC DMA handshake shared between the DMC sample reader
// and whatever drives it (CPU decode / DMA controller).
interface apu_dmc_reader_if;
   logic       reg_write;
   logic [1:0] reg_addr;
   logic       status_write;
   logic [7:0] reg_data;
   logic       dma_trigger;
   logic [15:0] dma_addr;
   logic       dma_ack;
   logic [7:0] dma_data;

   // CPU / DMA-controller side
   modport master (
      output reg_write, reg_addr, status_write, reg_data, dma_ack, dma_data,
      input  dma_trigger, dma_addr
   );

   // DMC reader side
   modport slave (
      input  reg_write, reg_addr, status_write, reg_data, dma_ack, dma_data,
      output dma_trigger, dma_addr
   );
endinterface

// File: rtl/apu_dmc_reader.sv
// APU delta-modulation channel: fetches sample bytes over the DMC DMA
// handshake, shifts them out one bit per timer tick as +/-2 steps on a 7-bit
// DAC, and raises the end-of-sample interrupt.
//
// Sample-buffer FSM:
//   state     | meaning
//   BUF_EMPTY | no byte buffered; a fetch is requested while bytes remain
//   BUF_FULL  | byte buffered, waiting for the next output-unit reload
module apu_dmc_reader #(
   parameter bit RATE_NTSC = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ce,
   apu_dmc_reader_if.slave   bus,
   output logic              irq,
   output logic              active,
   output logic [6:0]        dac
);

   typedef enum logic {BUF_EMPTY, BUF_FULL} buf_state_t;

   buf_state_t  buf_state, buf_state_nxt;
   logic [8:0]  timer;
   logic [3:0]  bits_left;
   logic [7:0]  shift_reg;
   logic [7:0]  sample_buf;
   logic        silence;
   logic        irq_en;
   logic        loop_en;
   logic [3:0]  rate_idx;
   logic [7:0]  start_reg;
   logic [7:0]  len_reg;
   logic [15:0] cur_addr;
   logic [11:0] bytes_remaining;

   logic        out_clk;
   logic        reload;
   logic        ack_ok;
   logic        wr_4010, wr_4011, wr_4012, wr_4013, wr_4015;
   logic [15:0] start_addr;
   logic [11:0] sample_len;
   logic [11:0] rem_dec;
   logic [15:0] addr_inc;

   // Timer reload value: the table period minus one, since the tick fires at 0.
   function automatic logic [8:0] period_m1(input logic [3:0] idx);
      logic [8:0] p;
      if (RATE_NTSC) begin
         case (idx)
            4'd0:  p = 9'd428;  4'd1:  p = 9'd380;  4'd2:  p = 9'd340;  4'd3:  p = 9'd320;
            4'd4:  p = 9'd286;  4'd5:  p = 9'd254;  4'd6:  p = 9'd226;  4'd7:  p = 9'd214;
            4'd8:  p = 9'd190;  4'd9:  p = 9'd160;  4'd10: p = 9'd142;  4'd11: p = 9'd128;
            4'd12: p = 9'd106;  4'd13: p = 9'd84;   4'd14: p = 9'd72;   default: p = 9'd54;
         endcase
      end else begin
         case (idx)
            4'd0:  p = 9'd398;  4'd1:  p = 9'd354;  4'd2:  p = 9'd316;  4'd3:  p = 9'd298;
            4'd4:  p = 9'd276;  4'd5:  p = 9'd236;  4'd6:  p = 9'd210;  4'd7:  p = 9'd198;
            4'd8:  p = 9'd176;  4'd9:  p = 9'd148;  4'd10: p = 9'd132;  4'd11: p = 9'd118;
            4'd12: p = 9'd98;   4'd13: p = 9'd78;   4'd14: p = 9'd66;   default: p = 9'd50;
         endcase
      end
      return p - 9'd1;
   endfunction

   assign wr_4010 = ce && bus.reg_write && (bus.reg_addr == 2'd0);
   assign wr_4011 = ce && bus.reg_write && (bus.reg_addr == 2'd1);
   assign wr_4012 = ce && bus.reg_write && (bus.reg_addr == 2'd2);
   assign wr_4013 = ce && bus.reg_write && (bus.reg_addr == 2'd3);
   assign wr_4015 = ce && bus.status_write;

   assign out_clk    = ce && (timer == 9'd0);
   assign reload     = out_clk && (bits_left == 4'd1);
   assign start_addr = 16'hC000 + {2'b00, start_reg, 6'd0};
   assign sample_len = {len_reg, 4'd0} + 12'd1;
   assign rem_dec    = bytes_remaining - 12'd1;
   assign addr_inc   = (cur_addr == 16'hFFFF) ? 16'h8000 : cur_addr + 16'd1;

   assign bus.dma_trigger = (buf_state == BUF_EMPTY) && (bytes_remaining != 12'd0);
   assign bus.dma_addr    = cur_addr;
   assign ack_ok          = ce && bus.dma_ack && bus.dma_trigger;
   assign active          = (bytes_remaining != 12'd0);

   // Buffer state register.
   always_ff @(posedge clk) begin
      if (reset) buf_state <= BUF_EMPTY;
      else       buf_state <= buf_state_nxt;
   end

   // Buffer fills on an honoured ack and drains into the shifter on reload;
   // the two cannot coincide because an ack needs an empty buffer.
   always_comb begin
      buf_state_nxt = buf_state;
      case (buf_state)
         BUF_EMPTY: if (ack_ok) buf_state_nxt = BUF_FULL;
         BUF_FULL:  if (reload) buf_state_nxt = BUF_EMPTY;
         default:   buf_state_nxt = BUF_EMPTY;
      endcase
   end

   // Rate timer: down-counter, reloads from the current rate on terminal count.
   always_ff @(posedge clk) begin
      if (reset)                 timer <= period_m1(4'd0);
      else if (ce) begin
         if (timer == 9'd0)      timer <= period_m1(rate_idx);
         else                    timer <= timer - 9'd1;
      end
   end

   // Output shifter and bit counter; reload takes the buffered byte if any.
   always_ff @(posedge clk) begin
      if (reset) begin
         shift_reg <= 8'd0;
         bits_left <= 4'd8;
         silence   <= 1'b1;
      end else if (out_clk) begin
         if (bits_left == 4'd1) begin
            bits_left <= 4'd8;
            if (buf_state == BUF_FULL) begin
               shift_reg <= sample_buf;
               silence   <= 1'b0;
            end else begin
               shift_reg <= shift_reg >> 1;
               silence   <= 1'b1;
            end
         end else begin
            shift_reg <= shift_reg >> 1;
            bits_left <= bits_left - 4'd1;
         end
      end
   end

   // Sample buffer capture.
   always_ff @(posedge clk) begin
      if (reset)       sample_buf <= 8'd0;
      else if (ack_ok) sample_buf <= bus.dma_data;
   end

   // DAC: a direct $4011 load overrides the delta step in the same cycle.
   always_ff @(posedge clk) begin
      if (reset) dac <= 7'd0;
      else if (wr_4011) dac <= bus.reg_data[6:0];
      else if (out_clk && !silence) begin
         if (shift_reg[0]) begin
            if (dac <= 7'd125) dac <= dac + 7'd2;
         end else if (dac >= 7'd2) begin
            dac <= dac - 7'd2;
         end
      end
   end

   // Configuration registers $4010/$4012/$4013.
   always_ff @(posedge clk) begin
      if (reset) begin
         irq_en    <= 1'b0;
         loop_en   <= 1'b0;
         rate_idx  <= 4'd0;
         start_reg <= 8'd0;
         len_reg   <= 8'd0;
      end else begin
         if (wr_4010) begin
            irq_en   <= bus.reg_data[7];
            loop_en  <= bus.reg_data[6];
            rate_idx <= bus.reg_data[3:0];
         end
         if (wr_4012) start_reg <= bus.reg_data;
         if (wr_4013) len_reg   <= bus.reg_data;
      end
   end

   // Reader address/length; a $4015 assignment overrides the ack update.
   always_ff @(posedge clk) begin
      if (reset) begin
         cur_addr        <= 16'hC000;
         bytes_remaining <= 12'd0;
      end else begin
         if (ack_ok) begin
            if ((rem_dec == 12'd0) && loop_en) begin
               cur_addr        <= start_addr;
               bytes_remaining <= sample_len;
            end else begin
               cur_addr        <= addr_inc;
               bytes_remaining <= rem_dec;
            end
         end
         if (wr_4015) begin
            if (!bus.reg_data[4]) begin
               bytes_remaining <= 12'd0;
            end else if (bytes_remaining == 12'd0) begin
               cur_addr        <= start_addr;
               bytes_remaining <= sample_len;
            end
         end
      end
   end

   // IRQ flag: set at end of a non-looping sample, cleared by $4015 or irq_en=0.
   always_ff @(posedge clk) begin
      if (reset) irq <= 1'b0;
      else begin
         if (ack_ok && (rem_dec == 12'd0) && !loop_en && irq_en) irq <= 1'b1;
         if (wr_4010 && !bus.reg_data[7]) irq <= 1'b0;
         if (wr_4015) irq <= 1'b0;
      end
   end

endmodule
